// File: rtl/buzz_timer_arbiter.sv
// Quiz-buzzer arbiter: synchronizes four contestant buttons, runs a BCD seconds
// countdown while the answer window is open, and latches the first press (lowest index wins).
module buzz_timer_arbiter #(
  parameter int TICK_DIV  = 100000000,
  parameter int COUNT_SEC = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       show_time,
  input  logic [3:0] btn,
  output logic       stoptime,
  output logic       endtime,
  output logic [1:0] winner,
  output logic       winner_valid,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0] INIT_TENS = 4'(COUNT_SEC / 10);
  localparam logic [3:0] INIT_ONES = 4'(COUNT_SEC % 10);

  typedef enum logic [1:0] {IDLE, COUNT, LOCKED, TIMEOUT} state_t;

  state_t        state_q, state_d;
  logic [3:0]    sync1_q, sync2_q, prev_q, press_q;
  logic          st_prev_q;
  logic [PW-1:0] presc_q, presc_d;
  logic          stoptime_q, stoptime_d;
  logic          endtime_q, endtime_d;
  logic [1:0]    winner_q, winner_d;
  logic          winner_valid_q, winner_valid_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic          tick;
  logic [1:0]    first_press;

  assign tick = (presc_q == TICK_LAST);

  always_comb begin
    first_press = 2'd3;
    if (press_q[0])      first_press = 2'd0;
    else if (press_q[1]) first_press = 2'd1;
    else if (press_q[2]) first_press = 2'd2;
  end

  // Abort beats a press, and a press beats the tick that would end the window.
  always_comb begin
    state_d        = state_q;
    presc_d        = presc_q;
    stoptime_d     = 1'b0;
    endtime_d      = 1'b0;
    winner_d       = winner_q;
    winner_valid_d = winner_valid_q;
    tens_d         = tens_q;
    ones_d         = ones_q;
    case (state_q)
      IDLE: begin
        presc_d = '0;
        if (show_time && !st_prev_q) begin
          state_d        = COUNT;
          tens_d         = INIT_TENS;
          ones_d         = INIT_ONES;
          winner_valid_d = 1'b0;
        end
      end
      COUNT: begin
        if (!show_time) begin
          state_d = IDLE;
          presc_d = '0;
        end else if (|press_q) begin
          state_d        = LOCKED;
          winner_d       = first_press;
          winner_valid_d = 1'b1;
          stoptime_d     = 1'b1;
          presc_d        = '0;
        end else if (tick) begin
          presc_d = '0;
          if (tens_q == 4'd0 && ones_q == 4'd1) begin
            ones_d    = 4'd0;
            endtime_d = 1'b1;
            state_d   = TIMEOUT;
          end else if (ones_q == 4'd0) begin
            ones_d = 4'd9;
            tens_d = tens_q - 4'd1;
          end else begin
            ones_d = ones_q - 4'd1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      LOCKED, TIMEOUT: begin
        if (!show_time) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      sync1_q        <= '0;
      sync2_q        <= '0;
      prev_q         <= '0;
      press_q        <= '0;
      st_prev_q      <= 1'b0;
      presc_q        <= '0;
      stoptime_q     <= 1'b0;
      endtime_q      <= 1'b0;
      winner_q       <= '0;
      winner_valid_q <= 1'b0;
      tens_q         <= '0;
      ones_q         <= '0;
    end else begin
      state_q        <= state_d;
      sync1_q        <= btn;
      sync2_q        <= sync1_q;
      prev_q         <= sync2_q;
      press_q        <= sync2_q & ~prev_q;
      st_prev_q      <= show_time;
      presc_q        <= presc_d;
      stoptime_q     <= stoptime_d;
      endtime_q      <= endtime_d;
      winner_q       <= winner_d;
      winner_valid_q <= winner_valid_d;
      tens_q         <= tens_d;
      ones_q         <= ones_d;
    end
  end

  assign stoptime     = stoptime_q;
  assign endtime      = endtime_q;
  assign winner       = winner_q;
  assign winner_valid = winner_valid_q;
  assign sec_tens     = tens_q;
  assign sec_ones     = ones_q;

endmodule

// File: tb/tb_buzz_timer_arbiter.sv
// Bench for buzz_timer_arbiter: directed scenarios with literal expectations plus
// random traffic, all compared every cycle against a seconds-level reference model.
module tb_buzz_timer_arbiter;

  localparam int TICK_DIV  = 4;
  localparam int COUNT_SEC = 3;
  localparam int P_CLOSED  = 0;
  localparam int P_RUN     = 1;
  localparam int P_DONE    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       show_time = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic       stoptime, endtime, winner_valid;
  logic [1:0] winner;
  logic [3:0] sec_tens, sec_ones;

  int checks = 0;
  int failures = 0;

  // Reference model state: window phase, whole seconds left, cycles since window opened.
  int   phase = P_CLOSED;
  int   secs = 0;
  int   elapsed = 0;
  int   exp_winner = 0;
  logic exp_valid = 1'b0;
  logic exp_stop = 1'b0;
  logic exp_end = 1'b0;
  logic st_seen = 1'b0;
  logic [3:0] s1 = 4'b0, s2 = 4'b0, s3 = 4'b0, s4 = 4'b0;

  buzz_timer_arbiter #(.TICK_DIV(TICK_DIV), .COUNT_SEC(COUNT_SEC)) dut (
    .clk(clk), .rst(rst), .show_time(show_time), .btn(btn),
    .stoptime(stoptime), .endtime(endtime), .winner(winner),
    .winner_valid(winner_valid), .sec_tens(sec_tens), .sec_ones(sec_ones)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      if (failures <= 40)
        $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [3:0] b, input logic r);
    show_time = st;
    btn = b;
    rst = r;
  endtask

  // Returns 1 time unit after the n-th following rising edge.
  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic openWindow();
    show_time = 1'b1;
    waitCycles(1);
  endtask

  task automatic closeWindow();
    applyStimulus(1'b0, 4'b0000, 1'b0);
    waitCycles(6);
  endtask

  // A press reaches the arbiter three edges after the button is sampled high,
  // and only if it was sampled low the edge before that.
  initial begin
    logic [3:0] press;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        phase = P_CLOSED; secs = 0; elapsed = 0;
        exp_winner = 0; exp_valid = 1'b0; exp_stop = 1'b0; exp_end = 1'b0;
        st_seen = 1'b0; s1 = 4'b0; s2 = 4'b0; s3 = 4'b0; s4 = 4'b0;
      end else begin
        press = s3 & ~s4;
        s4 = s3; s3 = s2; s2 = s1; s1 = btn;
        exp_stop = 1'b0;
        exp_end = 1'b0;
        if (phase == P_CLOSED) begin
          if (show_time && !st_seen) begin
            phase = P_RUN; secs = COUNT_SEC; elapsed = 0; exp_valid = 1'b0;
          end
        end else if (phase == P_RUN) begin
          if (!show_time) begin
            phase = P_CLOSED;
          end else if (press != 4'b0) begin
            for (int i = 3; i >= 0; i--) if (press[i]) exp_winner = i;
            exp_valid = 1'b1;
            exp_stop = 1'b1;
            phase = P_DONE;
          end else begin
            if (elapsed % TICK_DIV == TICK_DIV - 1) begin
              secs = secs - 1;
              if (secs == 0) begin
                exp_end = 1'b1;
                phase = P_DONE;
              end
            end
            elapsed++;
          end
        end else if (!show_time) begin
          phase = P_CLOSED;
        end
        st_seen = show_time;
      end
    end
  end

  initial begin
    logic prev_stop, prev_end;
    prev_stop = 1'b0;
    prev_end = 1'b0;
    forever begin
      @(negedge clk);
      checkOutput("stoptime", stoptime, exp_stop);
      checkOutput("endtime", endtime, exp_end);
      checkOutput("winner", winner, exp_winner);
      checkOutput("winner_valid", winner_valid, exp_valid);
      checkOutput("sec_tens", sec_tens, secs / 10);
      checkOutput("sec_ones", sec_ones, secs % 10);
      checkOutput("pulse_overlap", stoptime & endtime, 0);
      checkOutput("stop_repeat", stoptime & prev_stop, 0);
      checkOutput("end_repeat", endtime & prev_end, 0);
      prev_stop = stoptime;
      prev_end = endtime;
    end
  end

  initial begin
    int pulses;
    logic seen;
    int win_at;

    applyStimulus(1'b0, 4'b0000, 1'b1);
    waitCycles(3);
    checkOutput("reset_outputs", {stoptime, endtime, winner, winner_valid, sec_tens, sec_ones}, 0);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    waitCycles(2);

    // Timeout with no press.
    openWindow();
    checkOutput("to_start", {sec_tens, sec_ones}, 8'h03);
    waitCycles(4);
    checkOutput("to_sec2", {sec_tens, sec_ones}, 8'h02);
    waitCycles(4);
    checkOutput("to_sec1", {sec_tens, sec_ones}, 8'h01);
    waitCycles(4);
    checkOutput("to_sec0", {sec_tens, sec_ones}, 8'h00);
    checkOutput("to_endtime", endtime, 1);
    waitCycles(1);
    checkOutput("to_end_once", endtime, 0);
    closeWindow();

    // Single press at second 02.
    openWindow();
    waitCycles(4);
    btn = 4'b0100;
    waitCycles(3);
    checkOutput("p2_not_yet", stoptime, 0);
    waitCycles(1);
    checkOutput("p2_stoptime", stoptime, 1);
    checkOutput("p2_winner", winner, 2);
    checkOutput("p2_valid", winner_valid, 1);
    checkOutput("p2_digits", {sec_tens, sec_ones}, 8'h02);
    waitCycles(6);
    checkOutput("p2_frozen", {sec_tens, sec_ones}, 8'h02);
    closeWindow();
    checkOutput("p2_hold_winner", winner, 2);
    checkOutput("p2_hold_valid", winner_valid, 1);

    // Simultaneous presses resolve to the lowest index.
    openWindow();
    checkOutput("sim_valid_clear", winner_valid, 0);
    btn = 4'b1010;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      waitCycles(1);
      if (stoptime) pulses++;
    end
    checkOutput("sim_pulses", pulses, 1);
    checkOutput("sim_winner", winner, 1);
    checkOutput("sim_digits", {sec_tens, sec_ones}, 8'h03);
    closeWindow();

    // Button held before the window opens is ignored until re-pressed.
    btn = 4'b1000;
    waitCycles(5);
    openWindow();
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      waitCycles(1);
      if (stoptime) pulses++;
    end
    checkOutput("held_ignored", pulses, 0);
    btn = 4'b1001;
    seen = 1'b0;
    win_at = 3;
    for (int i = 0; i < 8; i++) begin
      waitCycles(1);
      if (stoptime && !seen) begin
        seen = 1'b1;
        win_at = winner;
      end
    end
    checkOutput("held_press_seen", seen, 1);
    checkOutput("held_winner", win_at, 0);
    closeWindow();

    // Press arriving with the final tick wins.
    openWindow();
    waitCycles(8);
    checkOutput("last_sec1", {sec_tens, sec_ones}, 8'h01);
    btn = 4'b0001;
    waitCycles(4);
    checkOutput("last_stoptime", stoptime, 1);
    checkOutput("last_endtime", endtime, 0);
    checkOutput("last_digits", {sec_tens, sec_ones}, 8'h01);
    waitCycles(3);
    checkOutput("last_no_end", endtime, 0);
    closeWindow();

    // Reset mid-countdown, released with show_time still high.
    openWindow();
    waitCycles(5);
    rst = 1'b1;
    #1;
    checkOutput("rst_outputs", {stoptime, endtime, winner, winner_valid, sec_tens, sec_ones}, 0);
    waitCycles(2);
    rst = 1'b0;
    waitCycles(1);
    checkOutput("rst_reopen", {sec_tens, sec_ones}, 8'h03);
    show_time = 1'b0;
    rst = 1'b1;
    waitCycles(1);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      waitCycles(1);
      if (stoptime || endtime) pulses++;
    end
    checkOutput("rst_no_pulses", pulses, 0);
    checkOutput("rst_digits", {sec_tens, sec_ones}, 8'h00);

    // Random traffic.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 499) == 0) rst = 1'b1;
      if ($urandom_range(0, 29) == 0) show_time = ~show_time;
      if ($urandom_range(0, 7) == 0) btn = 4'($urandom_range(0, 15));
      waitCycles(1);
    end

    applyStimulus(1'b0, 4'b0000, 1'b0);
    waitCycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
